lif_neuron_n: RTL

Parametrised leaky integrate-and-fire neuron, the next generation of our fixed 3-input LIF cell. It adds N signed synaptic inputs, configurable widths and constants, saturating arithmetic, an explicit refractory period and a tick enable. It sits between the spike-routing fabric and the per-layer spike aggregators, one instance per neuron.

---
 rtl/lif_pkg.sv | 38 +++
 rtl/lif_syn_sum.sv | 31 +++
 rtl/lif_neuron_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// ============================================================================
// lif_pkg : shared types and width/saturation helpers for the LIF neuron family
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lif_pkg;

  typedef enum logic [0:0] {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } lif_state_t;

  // Width of a masked signed sum of n_in weights of w bits, with one spare bit
  function automatic int sum_width(input int n_in, input int w);
    return w + $clog2(n_in) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxval, never less than one
  function automatic int bits_for(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic int sat_add(input int a, input int b, input int ceil);
    return (a + b > ceil) ? ceil : a + b;
  endfunction

  function automatic int floor_dec(input int a);
    return (a > 0) ? a - 1 : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lif_syn_sum.sv
// ============================================================================
// lif_syn_sum : combinational masked signed summation of N_IN synaptic weights
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lif_syn_sum
  import lif_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int W_WIDTH = 4,
  localparam int SUM_W  = sum_width(N_IN, W_WIDTH)
) (
  input  logic                      [N_IN-1:0] spike_i,
  input  logic              [N_IN*W_WIDTH-1:0] weights_i,
  output logic signed              [SUM_W-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_i[i]) begin
        sum_o = sum_o + {{(SUM_W-W_WIDTH){weights_i[i*W_WIDTH+W_WIDTH-1]}},
                         weights_i[i*W_WIDTH +: W_WIDTH]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_n.sv
// ============================================================================
// lif_neuron_n : N-input leaky integrate-and-fire neuron with refractory period
// Optional adaptive threshold enabled by defining LIF_ADAPT_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lif_neuron_n
  import lif_pkg::*;
#(
  parameter int N_IN      = 3,
  parameter int W_WIDTH   = 4,
  parameter int V_WIDTH   = 8,
  parameter int V_REST    = 6,
  parameter int V_LEAK    = 1,
  parameter int V_THRESH  = 14,
  parameter int T_REF     = 2,
  parameter int ADAPT_INC = 4,
  parameter int ADAPT_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic           [N_IN-1:0] spike_in,
  input  logic   [N_IN*W_WIDTH-1:0] weights,
  output logic                      spike_out,
  output logic        [V_WIDTH-1:0] v_mem,
  output logic                      refractory
);

  localparam int SUM_W  = sum_width(N_IN, W_WIDTH);
  localparam int CALC_W = max_int(V_WIDTH, SUM_W) + 2;
  localparam int CNT_W  = bits_for(T_REF);

  localparam logic        [V_WIDTH-1:0] REST_V = V_WIDTH'(V_REST);
  localparam logic signed  [CALC_W-1:0] REST_S = CALC_W'(V_REST);
  localparam logic signed  [CALC_W-1:0] LEAK_S = CALC_W'(V_LEAK);

  if (N_IN < 1 || V_REST >= V_THRESH || V_THRESH >= 2**V_WIDTH || T_REF < 0
      || ADAPT_INC < 0 || ADAPT_MAX < 0) begin : g_param_chk
    $error("lif_neuron_n: illegal parameter combination");
  end

  lif_state_t               state_q, state_d;
  logic       [V_WIDTH-1:0] v_mem_q, v_mem_d;
  logic         [CNT_W-1:0] cnt_q, cnt_d;
  logic                     spike_q, spike_d;

  logic signed  [SUM_W-1:0] syn_sum;
  logic signed [CALC_W-1:0] v_next;
  logic signed [CALC_W-1:0] th_eff;

  lif_syn_sum #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH)
  ) u_syn_sum (
    .spike_i   (spike_in),
    .weights_i (weights),
    .sum_o     (syn_sum)
  );

  // Widened so neither a large excitatory sum nor inhibition wraps before compare
  assign v_next = $signed({{(CALC_W-V_WIDTH){1'b0}}, v_mem_q})
                + $signed({{(CALC_W-SUM_W){syn_sum[SUM_W-1]}}, syn_sum})
                - LEAK_S;

`ifdef LIF_ADAPT_EN
  localparam int ADAPT_WIDTH = bits_for(ADAPT_MAX);

  if (V_THRESH + ADAPT_MAX >= 2**V_WIDTH) begin : g_adapt_range_chk
    $error("lif_neuron_n: V_THRESH+ADAPT_MAX must fit in V_WIDTH");
  end

  logic [ADAPT_WIDTH-1:0] offset_q, offset_d;

  always_comb begin
    offset_d = offset_q;
    if (en) begin
      if (spike_d) offset_d = ADAPT_WIDTH'(sat_add(int'(offset_q), ADAPT_INC, ADAPT_MAX));
      else         offset_d = ADAPT_WIDTH'(floor_dec(int'(offset_q)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) offset_q <= '0;
    else        offset_q <= offset_d;
  end

  assign th_eff = CALC_W'(V_THRESH) + $signed({{(CALC_W-ADAPT_WIDTH){1'b0}}, offset_q});
`else
  assign th_eff = CALC_W'(V_THRESH);
`endif

  always_comb begin
    state_d = state_q;
    v_mem_d = v_mem_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (v_next >= th_eff) begin
            spike_d = 1'b1;
            v_mem_d = REST_V;
            if (T_REF > 0) begin
              cnt_d   = CNT_W'(T_REF);
              state_d = ST_REFRACTORY;
            end
          end else if (v_next < REST_S) begin
            v_mem_d = REST_V;
          end else begin
            v_mem_d = v_next[V_WIDTH-1:0];
          end
        end
        ST_REFRACTORY: begin
          v_mem_d = REST_V;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_INTEGRATE;
        end
        default: state_d = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INTEGRATE;
      v_mem_q <= REST_V;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_mem_q <= v_mem_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out  = spike_q;
  assign v_mem      = v_mem_q;
  assign refractory = (state_q == ST_REFRACTORY);

endmodule

`default_nettype wire
